// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier.
//   - Fixed widths of operands, multiplier slice and product.
//   - FSM state encoding. Value 2'd3 is unused and is treated as IDLE.
//   - Shift applied to each partial product, selected by the pass counter.
package mul_seq_pkg;

  localparam int OP_W    = 8;
  localparam int SLICE_W = 4;
  localparam int PROD_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Shift for each pass: lo*lo, hi*lo, lo*hi, hi*hi.
  localparam logic [3:0] SHIFT_S0 = 4'd0;
  localparam logic [3:0] SHIFT_S1 = 4'd4;
  localparam logic [3:0] SHIFT_S2 = 4'd4;
  localparam logic [3:0] SHIFT_S3 = 4'd8;

  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = SHIFT_S0;
      2'd1:    sh = SHIFT_S1;
      2'd2:    sh = SHIFT_S2;
      default: sh = SHIFT_S3;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul4x4_array.sv
// Combinational 4x4 unsigned array multiplier.
// The partial products are formed with AND gates. They are summed row by row
// through ripple chains of full adders.
// Ports:
//   x  in  4  multiplicand slice
//   y  in  4  multiplier slice
//   p  out 8  x*y
module mul4x4_array
  import mul_seq_pkg::*;
(
  input  logic [SLICE_W-1:0]   x,
  input  logic [SLICE_W-1:0]   y,
  output logic [2*SLICE_W-1:0] p
);

  logic [3:0] pp [4];
  logic [4:0] row;
  logic [3:0] s;
  logic       c;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = x[j] & y[i];
      end
    end
    p    = '0;
    s    = '0;
    c    = 1'b0;
    // row holds the running sum, already shifted right by the index of the
    // current row. Bit 0 of each row is a final product bit.
    row  = {1'b0, pp[0]};
    p[0] = row[0];
    for (int i = 1; i < 4; i++) begin
      c = 1'b0;
      for (int j = 0; j < 4; j++) begin
        s[j] = row[j+1] ^ pp[i][j] ^ c;
        c    = (row[j+1] & pp[i][j]) | (c & (row[j+1] ^ pp[i][j]));
      end
      row  = {c, s};
      p[i] = row[0];
    end
    p[7:4] = row[4:1];
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential unsigned 8x8 multiplier. It reuses one 4x4 array slice over four
// passes and shift-accumulates the partial products into a 16-bit result.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer keeps valid (and its data) stable until that edge.
// out_valid/product are registered. They stay stable until the transfer.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   ena             global enable; low freezes all state
//   in_valid/ready  operand handshake (a, b)
//   out_valid/ready product handshake (product)
//   busy            high while passes are in progress
module mul8_seq_ctrl
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic              out_valid_q, out_valid_d;

  logic              st_idle, st_mul, st_done;
  logic              accept;
  logic [3:0]        x_sl, y_sl;
  logic [7:0]        pp;
  logic [PROD_W-1:0] pp_shifted;
  logic [PROD_W-1:0] acc_sum;

  // The unused encoding 2'd3 behaves exactly like IDLE.
  assign st_mul  = (state_q == ST_MUL);
  assign st_done = (state_q == ST_DONE);
  assign st_idle = !st_mul && !st_done;

  assign in_ready  = ena & (st_idle | (st_done & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = st_mul;

  // Bit 0 of step selects the high nibble of a. Bit 1 selects the high nibble of b.
  assign x_sl = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign y_sl = step_q[1] ? b_q[7:4] : b_q[3:0];

  mul4x4_array u_arr (
    .x (x_sl),
    .y (y_sl),
    .p (pp)
  );

  assign pp_shifted = {8'h00, pp} << step_shift(step_q);
  // The maximum total is 0xFE01, so the 16-bit sum never wraps.
  assign acc_sum    = acc_q + pp_shifted;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    if (ena) begin
      case (state_q)
        ST_MUL: begin
          acc_d  = acc_sum;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            product_d   = acc_sum;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      // An accept overrides the moves above. From DONE, it also consumes the product.
      if (accept) begin
        a_d     = a;
        b_d     = b;
        acc_d   = '0;
        step_d  = 2'd0;
        state_d = ST_MUL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and randomized bench for mul8_seq_ctrl. Inputs are driven at the
// falling edge, and outputs are sampled at the falling edge.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mul8_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  // Every task starts and ends just after a falling edge.

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (product !== 16'h0000) begin n_err++; $display("FAIL rst_product got %h want 0000", product); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_ena1 got %b want 1", in_ready); end
    ena = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready_ena0 got %b want 0", in_ready); end
    ena = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction with out_ready held high, from IDLE back to IDLE.
  task automatic do_mul(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] exp_p);
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul_busy got %b want 1", busy); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== (k == 4)) begin
        n_err++; $display("FAIL mul_latency edge %0d got out_valid %b want %b", k, out_valid, (k == 4));
      end
    end
    n_cmp++; if (product !== exp_p) begin n_err++; $display("FAIL mul_product %h*%h got %h want %h", ta, tb_, product, exp_p); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL mul_back_idle got ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_basic();
    do_mul(8'h12, 8'h34, 16'h03A8);
  endtask

  task automatic test_vectors();
    do_mul(8'hFF, 8'hFF, 16'hFE01);
    do_mul(8'hA5, 8'h00, 16'h0000);
    do_mul(8'h01, 8'h80, 16'h0080);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pa [3];
    logic [7:0]  pb [3];
    logic [15:0] pe [3];
    int nacc, nres;
    pa[0] = 8'h0F; pb[0] = 8'h0F; pe[0] = 16'h00E1;
    pa[1] = 8'hF0; pb[1] = 8'hF0; pe[1] = 16'hE100;
    pa[2] = 8'h10; pb[2] = 8'h10; pe[2] = 16'h0100;
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    nacc = 1; nres = 0;
    for (int e = 0; e <= 15; e++) begin
      @(negedge clk);
      // Accepts happen on edges 0, 5 and 10. After each accept, present the next pair.
      if (e % 5 == 0 && e < 15) begin
        if (nacc < 3) begin a = pa[nacc]; b = pb[nacc]; nacc++; end
        else in_valid = 1'b0;
      end
      n_cmp++;
      if (out_valid !== (e % 5 == 4)) begin
        n_err++; $display("FAIL b2b_valid edge %0d got %b want %b", e, out_valid, (e % 5 == 4));
      end
      if (out_valid === 1'b1 && nres < 3) begin
        n_cmp++;
        if (product !== pe[nres]) begin n_err++; $display("FAIL b2b_product %0d got %h want %h", nres, product, pe[nres]); end
        nres++;
      end
    end
    n_cmp++; if (nres != 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", nres); end
  endtask

  task automatic test_backpressure();
    int xfers;
    a = 8'h07; b = 8'h09; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_rise got %b want 1", out_valid); end
    // Offer new operands while stalled; they must not be taken.
    a = 8'hEE; b = 8'hEE; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || product !== 16'h003F || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cycle %0d got ov=%b p=%h ir=%b want 1 003f 0", k, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    xfers = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) xfers++;
      @(negedge clk);
    end
    n_cmp++; if (xfers != 1) begin n_err++; $display("FAIL bp_one_transfer got %0d want 1", xfers); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_stall();
    a = 8'h33; b = 8'h22; in_valid = 1'b1; out_ready = 1'b1; ena = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Two passes run, then three frozen edges, then the last two passes run.
    for (int e = 1; e <= 7; e++) begin
      ena = !(e >= 3 && e <= 5);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== (e == 7)) begin
        n_err++; $display("FAIL stall_latency edge %0d got %b want %b", e, out_valid, (e == 7));
      end
      if (e >= 3 && e <= 5) begin
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          n_err++; $display("FAIL stall_freeze edge %0d got busy=%b ir=%b want 1 0", e, busy, in_ready);
        end
      end
    end
    ena = 1'b1;
    n_cmp++; if (product !== 16'h06C6) begin n_err++; $display("FAIL stall_product got %h want 06c6", product); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a = 8'h33; b = 8'h22; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || product !== 16'h0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_values got ov=%b p=%h busy=%b want 0 0000 0", out_valid, product, busy);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale cycle %0d got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_random();
    int n_acc, n_out, cyc;
    logic [15:0] e;
    logic acc_now, xfer_now;
    n_acc = 0; n_out = 0; cyc = 0;
    in_valid = 1'b0;
    exp_q.delete();
    while ((n_acc < 1000 || exp_q.size() != 0) && cyc < 60000) begin
      ena       = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && n_acc < 1000 && $urandom_range(0, 1) == 1) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        in_valid = 1'b1;
      end
      #1;
      acc_now  = in_valid & in_ready;
      xfer_now = ena & out_valid & out_ready;
      if (xfer_now) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected_output got %h want none", product);
        end else begin
          e = exp_q.pop_front();
          if (product !== e) begin n_err++; $display("FAIL rand_product got %h want %h", product, e); end
        end
        n_out++;
      end
      if (acc_now) begin
        exp_q.push_back(16'(a) * 16'(b));
        n_acc++;
      end
      @(negedge clk);
      if (acc_now) in_valid = 1'b0;
      cyc++;
    end
    ena = 1'b1;
    in_valid = 1'b0;
    n_cmp++; if (n_out != n_acc) begin n_err++; $display("FAIL rand_count got %0d outputs want %0d", n_out, n_acc); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
